usb_line_encoder: RTL
=====================

USB_LINE_ENCODER -- requirements
Module: usb_line_encoder

Interface
REQ-001 Parameter CLKS_PER_BIT, 4, clk cycles per USB bit period; legal values are 2 or more.
REQ-002 clk  input  1  single clock, 48 MHz for full-speed; all logic rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 tx_data  input  8  packet byte, transmitted LSB first.
REQ-005 tx_valid  input  1  held high by source while packet bytes remain.
REQ-006 tx_ready  output  1  one-cycle pulse; tx_data is consumed on the cycle tx_valid and tx_ready are both high.
REQ-007 usb_dp  output  1  D+ line drive value.
REQ-008 usb_dn  output  1  D- line drive value.
REQ-009 usb_oe  output  1  high while the encoder owns the bus.
REQ-010 tx_busy  output  1  high in any state other than IDLE.

Function
REQ-011 Line symbols: J = dp 1/dn 0, K = dp 0/dn 1, SE0 = dp 0/dn 0; the same encoding as usb_line_decoder.
REQ-012 A bit strobe counter spans 0..CLKS_PER_BIT-1; line symbols change only at counter wrap, so every symbol lasts exactly CLKS_PER_BIT cycles.
REQ-013 FSM states: IDLE, SYNC, DATA, EOP_SE0, EOP_J.
REQ-014 IDLE: usb_oe=0, dp/dn=J, tx_ready=0, strobe counter held at 0.
REQ-015 IDLE->SYNC on the first clk edge with tx_valid=1; usb_oe rises on that edge and the first K is driven on that edge.
REQ-016 SYNC sends the bits 0x80 LSB first through NRZI, giving line pattern KJKJKJKK (8 bit periods).
REQ-017 tx_ready pulses on the last cycle of the final SYNC bit and on the last cycle of each byte's final data bit, including stuffed bits.
REQ-018 At the tx_ready pulse: tx_valid=1 loads tx_data and the FSM enters or stays in DATA; tx_valid=0 moves the FSM to EOP_SE0.
REQ-019 NRZI rule: a bit 0 toggles the line (J<->K); a bit 1 holds it.
REQ-020 Bit stuffing: a ones counter (3 bits) counts consecutive 1s from the start of SYNC.
REQ-021 When the ones counter reaches 6, one 0 bit (a toggle) is inserted before the next data bit, and the counter clears.
REQ-022 The ones counter clears on any 0 bit, stuffed or data.
REQ-023 A stuff bit due after a byte's last bit is sent before the tx_ready decision takes effect, so the stuff bit precedes the EOP.
REQ-024 EOP_SE0 drives SE0 for 2 bit periods, then EOP_J drives J for 1 bit period, then the FSM returns to IDLE with usb_oe=0.
REQ-025 tx_valid asserted during EOP or on the return-to-IDLE cycle is ignored until IDLE is reached; a new packet then starts the next cycle (tx_valid is level-sensitive).
REQ-026 tx_data changes while no transfer is occurring have no effect; the shift register holds its loaded byte.

Reset
REQ-027 Asserting rst_n=0 immediately forces IDLE: usb_oe=0, dp=J level, dn=J level, tx_ready=0, tx_busy=0, all counters 0, shift register 0.
REQ-028 Reset mid-packet truncates the packet with no EOP; after release, the first packet begins with a fresh SYNC.

Configuration
REQ-029 Macro USB_TX_LOW_SPEED_EN.
REQ-030 With USB_TX_LOW_SPEED_EN defined: J = dp 0/dn 1, K = dp 1/dn 0, and the CLKS_PER_BIT default is 32 (1.5 Mbps at 48 MHz).
REQ-031 Without USB_TX_LOW_SPEED_EN: full-speed polarity per REQ-011, and the CLKS_PER_BIT default is 4.
REQ-032 SE0, the FSM and the stuffing rules are identical in both modes.

Verification
REQ-033 Single byte 0x00, CLKS_PER_BIT=4 -> KJKJKJKK, then 8 toggles JKJKJKJK, SE0 x2, J; usb_oe high for exactly 76 cycles; tx_ready pulses twice.
REQ-034 Single byte 0xFF -> after SYNC the line holds K for 5 bits, one stuffed toggle to J, J held 3 bits, then EOP; total 17 data/SYNC bits; usb_oe high 80 cycles.
REQ-035 Bytes 0xA5,0x3C back-to-back with tx_valid held -> exactly 3 tx_ready pulses; decoded NRZI bitstream equals 0x80,0xA5,0x3C LSB first; no gap between bytes.
REQ-036 rst_n pulsed low mid-second byte -> usb_oe=0 and dp/dn=J asynchronously, with no EOP emitted; the next packet begins with a full SYNC.
REQ-037 Loopback through usb_line_decoder -> usb_line_state reports J/K/SE0 matching each driven symbol every cycle.
REQ-038 USB_TX_LOW_SPEED_EN defined, byte 0x00 -> inverted dp/dn for J/K, each bit lasting 32 cycles, SE0 unchanged.

Source files
------------

// File: rtl/usb_line_encoder.sv
// USB line encoder: SYNC, NRZI with bit stuffing, EOP, and per-symbol timing from a bit strobe counter.
// Define USB_TX_LOW_SPEED_EN for low-speed J/K polarity and a 32-cycle default bit period.
module usb_line_encoder #(
`ifdef USB_TX_LOW_SPEED_EN
  parameter int CLKS_PER_BIT = 32
`else
  parameter int CLKS_PER_BIT = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       usb_dp,
  output logic       usb_dn,
  output logic       usb_oe,
  output logic       tx_busy
);

`ifdef USB_TX_LOW_SPEED_EN
  localparam logic J_DP = 1'b0;
`else
  localparam logic J_DP = 1'b1;
`endif

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [2:0]    ones_q, ones_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          line_q, line_d;   // 1 = J level, 0 = K level

  logic       wrap;
  logic       stuff_due;
  logic [7:0] cur_byte;
  logic [2:0] nxt_idx;
  logic       send_bit;
  logic       bit_val;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    ones_d    = ones_q;
    shreg_d   = shreg_q;
    line_d    = line_q;
    tx_ready  = 1'b0;
    send_bit  = 1'b0;
    bit_val   = 1'b0;

    wrap      = (cnt_q == CNT_MAX);
    stuff_due = (ones_q == 3'd6);
    cur_byte  = (state_q == SYNC) ? SYNC_BYTE : shreg_q;
    nxt_idx   = bit_idx_q + 3'd1;

    if (state_q != IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        line_d = 1'b1;
        if (tx_valid) begin
          state_d   = SYNC;
          bit_idx_d = 3'd0;
          ones_d    = 3'd0;
          line_d    = 1'b0;  // first SYNC bit is a 0: J toggles to K
        end
      end
      SYNC, DATA: begin
        // A pending stuff bit always goes out before the byte-boundary decision.
        tx_ready = wrap && (bit_idx_q == 3'd7) && !stuff_due;
        if (wrap) begin
          if (stuff_due) begin
            line_d = ~line_q;
            ones_d = 3'd0;
          end else if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            if (tx_valid) begin
              state_d  = DATA;
              shreg_d  = tx_data;
              send_bit = 1'b1;
              bit_val  = tx_data[0];
            end else begin
              state_d = EOP_SE0;
              line_d  = 1'b1;
            end
          end else begin
            bit_idx_d = nxt_idx;
            send_bit  = 1'b1;
            bit_val   = cur_byte[nxt_idx];
          end
        end
      end
      EOP_SE0: begin
        if (wrap) begin
          if (bit_idx_q == 3'd1) begin
            state_d   = EOP_J;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = 3'd1;
          end
        end
      end
      EOP_J: begin
        if (wrap) begin
          state_d   = IDLE;
          bit_idx_d = 3'd0;
          ones_d    = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (send_bit) begin
      if (bit_val) begin
        ones_d = ones_q + 3'd1;
      end else begin
        line_d = ~line_q;
        ones_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      ones_q    <= 3'd0;
      shreg_q   <= 8'h00;
      line_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      ones_q    <= ones_d;
      shreg_q   <= shreg_d;
      line_q    <= line_d;
    end
  end

  logic se0;
  assign se0     = (state_q == EOP_SE0);
  assign usb_oe  = (state_q != IDLE);
  assign tx_busy = (state_q != IDLE);
  assign usb_dp  = se0 ? 1'b0 : (line_q ? J_DP : ~J_DP);
  assign usb_dn  = se0 ? 1'b0 : (line_q ? ~J_DP : J_DP);

endmodule
